// File: rtl/my_div4.sv
// 4-bit unsigned restoring divider: one quotient bit per cycle, MSB-first,
// with a divide-by-zero shortcut that skips the iteration sequence.
module my_div4 (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       START,
  input  logic [3:0] N,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic [3:0] R,
  output logic       BUSY,
  output logic       DONE,
  output logic       DZ,
  output logic       Z
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] n_reg;
  logic [3:0] d_reg;
  logic [3:0] quo;
  logic [4:0] rem;
  logic [1:0] cnt;
  logic       accept;
  logic [4:0] rem_sh;
  logic [5:0] trial;
  logic       no_borrow;

  // Handshake: START is accepted on any edge where the FSM is in IDLE or FIN
  // (never in RUN); the result is marked by a one-cycle DONE pulse and Q/R/DZ
  // then hold until the next DONE.
  assign accept = START && (state != RUN);

  // Bit 5 of the trial sum is the carry out: set means no borrow.
  always_comb begin
    rem_sh    = {rem[3:0], n_reg[3]};
    trial     = {1'b0, rem_sh} + {1'b0, ~{1'b0, d_reg}} + 6'd1;
    no_borrow = trial[5];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (START) state_nxt = (D == 4'd0) ? FIN : RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (cnt == 2'd3) state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // BUSY and DONE are registered images of the state, so they lag it by one edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      Q     <= 4'd0;
      R     <= 4'd0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      DZ    <= 1'b0;
      n_reg <= 4'd0;
      d_reg <= 4'd0;
      quo   <= 4'd0;
      rem   <= 5'd0;
      cnt   <= 2'd0;
    end else begin
      BUSY <= (state == RUN);
      DONE <= (state == FIN);
      if (state == FIN) begin
        if (d_reg == 4'd0) begin
          Q  <= 4'hF;
          R  <= n_reg;
          DZ <= 1'b1;
        end else begin
          Q  <= quo;
          R  <= rem[3:0];
          DZ <= 1'b0;
        end
      end
      if (accept) begin
        n_reg <= N;
        d_reg <= D;
        quo   <= 4'd0;
        rem   <= 5'd0;
        cnt   <= 2'd0;
      end else if (state == RUN) begin
        rem   <= no_borrow ? trial[4:0] : rem_sh;
        quo   <= {quo[2:0], no_borrow};
        n_reg <= {n_reg[2:0], 1'b0};
        cnt   <= cnt + 2'd1;
      end
    end
  end

  assign Z = (Q == 4'd0);

endmodule

// File: tb/tb_my_div4.sv
// Bench for my_div4: directed cases, reset aborts, an exhaustive back-to-back
// sweep and random traffic, all scored against an arithmetic reference.
module tb_my_div4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       dz;
  logic       z;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q[$];
  logic [3:0] last_q;
  logic [3:0] last_r;
  logic       last_dz;

  my_div4 dut (
    .CLK   (clk),
    .RESETN(resetn),
    .START (start),
    .N     (dividend),
    .D     (divisor),
    .Q     (q),
    .R     (r),
    .BUSY  (busy),
    .DONE  (done),
    .DZ    (dz),
    .Z     (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference result packed as {quotient, remainder, dz}.
  function automatic logic [8:0] ref_div(input logic [3:0] n, input logic [3:0] d);
    int qq, rr;
    if (d == 4'd0) return {4'hF, n, 1'b1};
    qq = int'(n) / int'(d);
    rr = int'(n) % int'(d);
    return {qq[3:0], rr[3:0], 1'b0};
  endfunction

  task automatic check_held(input string tag);
    check({tag, "_q"},  q,  last_q);
    check({tag, "_r"},  r,  last_r);
    check({tag, "_dz"}, dz, last_dz);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_q"},    q,    0);
    check({tag, "_r"},    r,    0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dz"},   dz,   0);
    check({tag, "_z"},    z,    1);
  endtask

  task automatic start_op(input logic [3:0] n, input logic [3:0] d);
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    tick;
  endtask

  // Called just after the accepting edge. With chain set, START is raised in
  // the result cycle so that the same edge accepts the next operation.
  task automatic run_div(input logic [3:0] n, input logic [3:0] d, input bit noise,
                         input bit chain, input logic [3:0] nn, input logic [3:0] dn);
    logic [8:0] e;
    exp_q.push_back(ref_div(n, d));
    if (d != 4'd0) begin
      check("busy_edge0", busy, 0);
      for (int i = 1; i <= 4; i++) begin
        if (noise) begin
          start    = 1'b1;
          dividend = 4'($urandom_range(0, 15));
          divisor  = 4'($urandom_range(0, 15));
        end else begin
          start = 1'b0;
        end
        tick;
        check("busy_run", busy, 1);
        check("done_run", done, 0);
        check_held("hold_run");
      end
    end
    start    = chain;
    dividend = nn;
    divisor  = dn;
    tick;
    e = exp_q.pop_front();
    check("done_pulse", done, 1);
    check("busy_fin",   busy, 0);
    check("q",  q,  e[8:5]);
    check("r",  r,  e[4:1]);
    check("dz", dz, e[0]);
    check("z",  z,  (e[8:5] == 4'd0));
    last_q  = e[8:5];
    last_r  = e[4:1];
    last_dz = e[0];
    if (!chain) begin
      start = 1'b0;
      tick;
      check("done_drop", done, 0);
      check("busy_idle", busy, 0);
      check_held("hold_idle");
    end
  endtask

  initial begin
    logic [8:0] k;
    logic [8:0] nxt;
    logic [3:0] rn, rd, pn, pd;
    bit         ch;

    resetn   = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    last_q   = 4'd0;
    last_r   = 4'd0;
    last_dz  = 1'b0;
    tick;
    tick;
    check_cleared("reset");
    resetn = 1'b1;
    tick;

    start_op(4'd13, 4'd3);  run_div(4'd13, 4'd3, 0, 0, 4'd0, 4'd0);
    start_op(4'd15, 4'd1);  run_div(4'd15, 4'd1, 0, 0, 4'd0, 4'd0);
    start_op(4'd2,  4'd9);  run_div(4'd2,  4'd9, 0, 0, 4'd0, 4'd0);
    start_op(4'd7,  4'd0);  run_div(4'd7,  4'd0, 0, 0, 4'd0, 4'd0);

    // START held high with other operands during RUN, then re-accepted in FIN.
    start_op(4'd13, 4'd3);  run_div(4'd13, 4'd3, 1, 1, 4'd11, 4'd2);
    run_div(4'd11, 4'd2, 0, 0, 4'd0, 4'd0);

    // Reset at edge 3 of a run aborts it.
    start_op(4'd13, 4'd3);
    start = 1'b0;
    tick;
    tick;
    resetn = 1'b0;
    tick;
    check_cleared("rst_mid");
    last_q  = 4'd0;
    last_r  = 4'd0;
    last_dz = 1'b0;
    resetn  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("rst_mid_done", done, 0);
      check("rst_mid_busy", busy, 0);
    end
    start_op(4'd9, 4'd2);   run_div(4'd9, 4'd2, 0, 0, 4'd0, 4'd0);

    // Reset on the edge leaving FIN suppresses DONE.
    start_op(4'd5, 4'd2);
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    resetn = 1'b0;
    tick;
    check_cleared("rst_fin");
    last_q  = 4'd0;
    last_r  = 4'd0;
    last_dz = 1'b0;
    resetn  = 1'b1;
    tick;
    check("rst_fin_after", done, 0);

    // Reset wins over START on the same edge.
    resetn   = 1'b0;
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd3;
    tick;
    resetn = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("rst_prio_busy", busy, 0);
      check("rst_prio_done", done, 0);
    end
    start_op(4'd0, 4'd0);   run_div(4'd0, 4'd0, 0, 0, 4'd0, 4'd0);

    // Exhaustive back-to-back sweep.
    start_op(4'd0, 4'd0);
    for (int i = 0; i < 256; i++) begin
      k   = 9'(i);
      nxt = 9'(i + 1);
      run_div(k[7:4], k[3:0], bit'($urandom_range(0, 1)), (i != 255), nxt[7:4], nxt[3:0]);
    end

    // Random traffic, randomly chained or separated.
    pn = 4'($urandom_range(0, 15));
    pd = 4'($urandom_range(0, 15));
    start_op(pn, pd);
    for (int i = 0; i < 60; i++) begin
      rn = 4'($urandom_range(0, 15));
      rd = (($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      ch = (i != 59) && bit'($urandom_range(0, 1));
      run_div(pn, pd, bit'($urandom_range(0, 1)), ch, rn, rd);
      if (!ch && i != 59) begin
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick;
        start_op(rn, rd);
      end
      pn = rn;
      pd = rd;
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/my_div4.md
MY_DIV4 -- requirements
Module: my_div4

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 4 bits unsigned.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESETN  input  1  reset, synchronous, active-low; sampled only on the rising CLK edge.
REQ-004 START  input  1  request to begin a division; sampled on the rising CLK edge.
REQ-005 N  input  4  dividend; captured on the edge that accepts START.
REQ-006 D  input  4  divisor; captured on the edge that accepts START.
REQ-007 Q  output  4  quotient, registered.
REQ-008 R  output  4  remainder, registered.
REQ-009 BUSY  output  1  high while an iteration sequence is in progress, registered.
REQ-010 DONE  output  1  one-cycle pulse marking valid Q/R/DZ, registered.
REQ-011 DZ  output  1  divide-by-zero flag for the last completed operation, registered.
REQ-012 Z  output  1  high when Q==0, derived combinationally from registered Q.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, FIN.
REQ-014 IDLE: on START=1 the block SHALL latch N and D, clear its internal partial remainder and iteration counter, and go to RUN, or go to FIN if D==0.
REQ-015 RUN: each cycle SHALL perform one restoring step: shift the 5-bit partial remainder left, taking in the next dividend bit MSB-first, then trial-subtract D as remainder + ~{0,D} + 1.
REQ-016 Each step SHALL keep the difference and shift in quotient bit 1 if the subtraction does not borrow, and otherwise keep the shifted remainder and shift in 0.
REQ-017 After exactly 4 RUN cycles the FSM SHALL go to FIN, loading Q with the quotient and R with the low 4 bits of the remainder.
REQ-018 FIN: DONE=1 for exactly this one cycle; the next state SHALL be IDLE, or RUN/FIN if START=1, with FIN accepted exactly like IDLE.
REQ-019 Latency: with START accepted at edge 0 and D!=0, BUSY SHALL be 1 after edges 1-4 and DONE SHALL be 1 after edge 5.
REQ-020 Divide by zero (D==0): after edge 1 the outputs SHALL be DONE=1, DZ=1, Q=4'b1111, R=N, with BUSY never asserted.
REQ-021 DZ SHALL be 0 after any completed operation with D!=0.
REQ-022 Q, R and DZ SHALL hold their last completed values until the next FIN; they SHALL not change during RUN.
REQ-023 START SHALL be ignored while in RUN; N and D changes during RUN SHALL not affect the result.
REQ-024 Results SHALL satisfy N == Q*D + R with R < D for every D!=0, including N<D, which gives Q=0 and R=N.

Reset
REQ-025 RESETN=0 at a rising edge SHALL force IDLE and set Q=0, R=0, BUSY=0, DONE=0, DZ=0, so Z=1.
REQ-026 Reset asserted mid-RUN or in FIN SHALL abort the operation with no DONE pulse; the clock edge that deasserts reset SHALL not accept START.
REQ-027 Reset SHALL take priority over START when both are active on the same edge.

Verification
REQ-028 N=13, D=3, START pulse -> BUSY high for 4 cycles; after edge 5: DONE=1, Q=4, R=1, DZ=0, Z=0.
REQ-029 N=15, D=1 -> Q=15, R=0; then N=2, D=9 -> Q=0, R=2, Z=1.
REQ-030 N=7, D=0 -> after edge 1: DONE=1, DZ=1, Q=15, R=7; BUSY stays 0.
REQ-031 START re-pulsed with N=0, D=5 during RUN of 13/3 -> ignored; result Q=4, R=1; START in the FIN cycle -> next result valid 5 edges later.
REQ-032 RESETN low at edge 3 of a run -> all outputs 0, no DONE; a fresh 9/2 afterwards -> Q=4, R=1.
REQ-033 Exhaustive sweep of all 256 (N, D) pairs back-to-back -> every result checked against REQ-020 and REQ-024.
